dac_cfg_sequencer: RTL and testbench

DAC_CFG_SEQUENCER -- requirements
Module: dac_cfg_sequencer

---
 rtl/dac_cfg_pkg.sv | 22 ++
 rtl/dac_cfg_timeout.sv | 31 +++
 rtl/dac_cfg_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_dac_cfg_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_cfg_pkg.sv
// Shared types and constants for the DAC configuration sequencer.
package dac_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    FINISH  = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_RESP     = 2'd1;
  localparam logic [1:0] ERR_MISMATCH = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [1:0] AXI_OKAY = 2'b00;

  localparam int REG_STRIDE = 4;

endpackage

// File: rtl/dac_cfg_timeout.sv
// Per-phase watchdog: down-counter reloaded on every state entry,
// expired on the C_TIMEOUT-th enabled cycle after the reload.
module dac_cfg_timeout #(
  parameter int C_TIMEOUT = 255
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(C_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // reload on state entry, count down while the phase is waiting
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = enable && (cnt == '0);

endmodule

// File: rtl/dac_cfg_sequencer.sv
// Writes a block of configuration words over AXI4-Lite, optionally reads
// them back for comparison, and reports the first failure.
//
// state   | meaning
// IDLE    | waiting for start
// WR_ADDR | AW and W offered for word k
// WR_RESP | waiting for B of word k
// RD_ADDR | AR offered for word k
// RD_DATA | waiting for R of word k, compared to latched word
// FINISH  | one-cycle done pulse, back to IDLE
module dac_cfg_sequencer
  import dac_cfg_pkg::*;
#(
  parameter int C_ADDR_W    = 4,
  parameter int C_BASE_ADDR = 0,
  parameter int C_NUM_REGS  = 4,
  parameter int C_TIMEOUT   = 255
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    start,
  input  logic [32*C_NUM_REGS-1:0] cfg_words,
  input  logic [2:0]              num_regs,
  input  logic                    verify_en,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [1:0]              err_code,
  output logic [1:0]              err_idx,
  output logic [C_ADDR_W-1:0]     m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [31:0]             m_axi_wdata,
  output logic [3:0]              m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [C_ADDR_W-1:0]     m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [31:0]             m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int IDX_W = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
  localparam logic [C_ADDR_W-1:0] BASE   = C_ADDR_W'(C_BASE_ADDR);
  localparam logic [C_ADDR_W-1:0] STRIDE = C_ADDR_W'(REG_STRIDE);

  state_t                  state, state_nxt;
  logic [32*C_NUM_REGS-1:0] cfg_lat;
  logic                    verify_lat;
  logic [IDX_W-1:0]        idx, last_idx;
  logic [31:0]             word;
  logic [C_ADDR_W-1:0]     addr;
  logic                    is_last, aw_ok, w_ok, tmo;
  logic                    err_set;
  logic [1:0]              err_code_set;

  assign word    = cfg_lat[{idx, 5'd0} +: 32];
  assign addr    = BASE + C_ADDR_W'(idx) * STRIDE;
  assign is_last = (idx == last_idx);
  assign aw_ok   = !m_axi_awvalid || m_axi_awready;
  assign w_ok    = !m_axi_wvalid || m_axi_wready;

  assign busy = (state == WR_ADDR) || (state == WR_RESP) ||
                (state == RD_ADDR) || (state == RD_DATA);
  assign done = (state == FINISH);

  assign m_axi_awaddr = addr;
  assign m_axi_araddr = addr;
  assign m_axi_wdata  = word;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = 4'hF;
  assign m_axi_bready = (state == WR_RESP);
  assign m_axi_rready = (state == RD_DATA);

  dac_cfg_timeout #(.C_TIMEOUT(C_TIMEOUT)) u_timeout (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .clear  (state_nxt != state),
    .enable (busy),
    .expired(tmo)
  );

  // next state and error detection; a handshake in the expiry cycle wins
  always_comb begin
    state_nxt    = state;
    err_set      = 1'b0;
    err_code_set = ERR_NONE;
    case (state)
      IDLE: if (start) state_nxt = WR_ADDR;
      WR_ADDR: begin
        if (aw_ok && w_ok) begin
          state_nxt = WR_RESP;
        end else if (tmo) begin
          state_nxt = FINISH; err_set = 1'b1; err_code_set = ERR_TIMEOUT;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != AXI_OKAY) begin
            state_nxt = FINISH; err_set = 1'b1; err_code_set = ERR_RESP;
          end else if (!is_last) begin
            state_nxt = WR_ADDR;
          end else begin
            state_nxt = verify_lat ? RD_ADDR : FINISH;
          end
        end else if (tmo) begin
          state_nxt = FINISH; err_set = 1'b1; err_code_set = ERR_TIMEOUT;
        end
      end
      RD_ADDR: begin
        if (m_axi_arready) begin
          state_nxt = RD_DATA;
        end else if (tmo) begin
          state_nxt = FINISH; err_set = 1'b1; err_code_set = ERR_TIMEOUT;
        end
      end
      RD_DATA: begin
        if (m_axi_rvalid) begin
          if (m_axi_rresp != AXI_OKAY) begin
            state_nxt = FINISH; err_set = 1'b1; err_code_set = ERR_RESP;
          end else if (m_axi_rdata != word) begin
            state_nxt = FINISH; err_set = 1'b1; err_code_set = ERR_MISMATCH;
          end else begin
            state_nxt = is_last ? FINISH : RD_ADDR;
          end
        end else if (tmo) begin
          state_nxt = FINISH; err_set = 1'b1; err_code_set = ERR_TIMEOUT;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state register, job latch, word index and sticky error fields
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= IDLE;
      cfg_lat    <= '0;
      verify_lat <= 1'b0;
      idx        <= '0;
      last_idx   <= '0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      err_idx    <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        cfg_lat    <= cfg_words;
        verify_lat <= verify_en;
        idx        <= '0;
        err        <= 1'b0;
        err_code   <= ERR_NONE;
        err_idx    <= 2'd0;
        if (num_regs == 3'd0 || int'(num_regs) > C_NUM_REGS)
          last_idx <= IDX_W'(C_NUM_REGS - 1);
        else
          last_idx <= IDX_W'(num_regs - 3'd1);
      end
      if (err_set) begin
        err      <= 1'b1;
        err_code <= err_code_set;
        err_idx  <= 2'(idx);
      end
      if ((state == WR_RESP && state_nxt == WR_ADDR) ||
          (state == RD_DATA && state_nxt == RD_ADDR))
        idx <= idx + IDX_W'(1);
      else if (state == WR_RESP && state_nxt == RD_ADDR)
        idx <= '0;
    end
  end

  // request valids: raised on phase entry, each dropped after its own handshake
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_arvalid <= 1'b0;
    end else begin
      if (state_nxt == WR_ADDR && state != WR_ADDR) begin
        m_axi_awvalid <= 1'b1;
        m_axi_wvalid  <= 1'b1;
      end else begin
        m_axi_awvalid <= (state_nxt == WR_ADDR) && m_axi_awvalid && !m_axi_awready;
        m_axi_wvalid  <= (state_nxt == WR_ADDR) && m_axi_wvalid && !m_axi_wready;
      end
      m_axi_arvalid <= (state_nxt == RD_ADDR);
    end
  end

endmodule

// File: tb/tb_dac_cfg_sequencer.sv
// Directed bench for dac_cfg_sequencer with a small AXI4-Lite memory slave.
module tb_dac_cfg_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] cfg_words;
  logic [2:0]   num_regs;
  logic         verify_en;
  logic         busy, done, err;
  logic [1:0]   err_code, err_idx;
  logic [3:0]   m_axi_awaddr, m_axi_araddr;
  logic [2:0]   m_axi_awprot, m_axi_arprot;
  logic         m_axi_awvalid, m_axi_awready;
  logic [31:0]  m_axi_wdata;
  logic [3:0]   m_axi_wstrb;
  logic         m_axi_wvalid, m_axi_wready;
  logic [1:0]   m_axi_bresp;
  logic         m_axi_bvalid, m_axi_bready;
  logic         m_axi_arvalid, m_axi_arready;
  logic [31:0]  m_axi_rdata;
  logic [1:0]   m_axi_rresp;
  logic         m_axi_rvalid, m_axi_rready;

  always #5 clk = ~clk;

  dac_cfg_sequencer #(.C_TIMEOUT(16)) dut (
    .ACLK(clk), .ARESET(rst), .start(start), .cfg_words(cfg_words),
    .num_regs(num_regs), .verify_en(verify_en), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .err_idx(err_idx),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int checks = 0;
  int errors = 0;

  // slave knobs
  int   aw_delay = 0;
  int   bad_b    = -1;
  int   bad_r    = -1;
  logic ar_never = 1'b0;

  // transaction log
  int          cyc, n_aw, n_w, n_b, n_ar, n_r, aw_first, w_first;
  int          done_cnt, ar_high, aw_unstable, overlap, aw_wait;
  logic        aw_wait_prev;
  logic [3:0]  aw_addr_prev;
  logic [3:0]  aw_q [8];
  logic [3:0]  ar_q [8];
  logic [31:0] w_q  [8];
  logic [31:0] mem  [4];

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    cyc = 0; n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
    aw_first = -1; w_first = -1; done_cnt = 0; ar_high = 0;
    aw_unstable = 0; overlap = 0; aw_wait = 0;
    aw_wait_prev = 1'b0; aw_addr_prev = 4'd0;
    for (int i = 0; i < 8; i++) begin aw_q[i] = '0; ar_q[i] = '0; w_q[i] = '0; end
    for (int i = 0; i < 4; i++) mem[i] = '0;
  endtask

  // handshake monitor: samples pre-edge values at each rising edge
  always @(posedge clk) begin
    if (!rst) begin
      cyc++;
      if (aw_wait_prev && (!m_axi_awvalid || m_axi_awaddr != aw_addr_prev)) aw_unstable++;
      aw_wait_prev = m_axi_awvalid && !m_axi_awready;
      aw_addr_prev = m_axi_awaddr;
      if (m_axi_awvalid && m_axi_awready) begin
        if (n_aw == 0) aw_first = cyc;
        if (n_aw < 8) aw_q[n_aw] = m_axi_awaddr;
        n_aw++;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (n_w == 0) w_first = cyc;
        if (n_w < 8) w_q[n_w] = m_axi_wdata;
        n_w++;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        if (n_b < 8) mem[aw_q[n_b][3:2]] = w_q[n_b];
        n_b++;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        if (n_ar < 8) ar_q[n_ar] = m_axi_araddr;
        n_ar++;
      end
      if (m_axi_rvalid && m_axi_rready) n_r++;
      if (m_axi_arvalid) ar_high++;
      if (done) done_cnt++;
      if ((m_axi_arvalid || m_axi_rready) && (m_axi_awvalid || m_axi_wvalid || m_axi_bready))
        overlap++;
    end
  end

  // slave responses, updated mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
      aw_wait = 0;
    end else begin
      if (m_axi_awvalid) begin
        m_axi_awready = (aw_wait >= aw_delay);
        aw_wait++;
      end else begin
        m_axi_awready = 1'b0;
        aw_wait = 0;
      end
      m_axi_wready  = m_axi_wvalid;
      m_axi_bvalid  = (n_aw > n_b) && (n_w > n_b);
      m_axi_bresp   = (n_b == bad_b) ? 2'b10 : 2'b00;
      m_axi_arready = m_axi_arvalid && !ar_never;
      m_axi_rvalid  = (n_ar > n_r);
      m_axi_rresp   = 2'b00;
      if (n_r == bad_r) m_axi_rdata = 32'h0000_DEAD;
      else if (n_r < 8) m_axi_rdata = mem[ar_q[n_r][3:2]];
      else m_axi_rdata = '0;
    end
  end

  task automatic run(input string tag, input logic [2:0] nr, input logic ve, input logic poke);
    @(negedge clk);
    num_regs = nr; verify_en = ve; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_val({tag, "_busy"}, 32'(busy), 32'd1);
    if (poke) begin
      @(negedge clk); start = 1'b1; num_regs = 3'd1;
      @(negedge clk); start = 1'b0;
    end
    for (int i = 0; i < 400; i++) begin
      if (done_cnt != 0) break;
      @(negedge clk);
    end
    if (done_cnt == 0) chk_val({tag, "_done_timeout"}, 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic between();
    @(posedge clk); #1;
    clr_stats();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cfg_words = '0; num_regs = 3'd0; verify_en = 1'b0;
    clr_stats();
    repeat (3) @(negedge clk);
    chk_val("rst_busy", 32'(busy), 0);
    chk_val("rst_done", 32'(done), 0);
    chk_val("rst_err", 32'(err), 0);
    chk_val("rst_err_code", 32'(err_code), 0);
    chk_val("rst_err_idx", 32'(err_idx), 0);
    chk_val("rst_valids", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
    chk_val("rst_readies", {30'd0, m_axi_bready, m_axi_rready}, 0);
    rst = 1'b0;

    // full write + verify, ideal slave, a second start while busy
    between();
    cfg_words = {32'd4, 32'd3, 32'd2, 32'd1};
    run("t1", 3'd4, 1'b1, 1'b1);
    chk_val("t1_n_aw", n_aw, 4);
    for (int i = 0; i < 4; i++) begin
      chk_val($sformatf("t1_awaddr%0d", i), 32'(aw_q[i]), 32'(4 * i));
      chk_val($sformatf("t1_wdata%0d", i), w_q[i], 32'(i + 1));
      chk_val($sformatf("t1_araddr%0d", i), 32'(ar_q[i]), 32'(4 * i));
    end
    chk_val("t1_n_ar", n_ar, 4);
    chk_val("t1_err", 32'(err), 0);
    chk_val("t1_done_pulses", done_cnt, 1);
    chk_val("t1_busy_end", 32'(busy), 0);
    chk_val("t1_wstrb_prot", {25'd0, m_axi_wstrb, m_axi_awprot}, 32'h78);
    chk_val("t1_overlap", overlap, 0);

    // delayed awready: W completes first, AW held
    between();
    aw_delay = 3;
    cfg_words = {32'h44, 32'h33, 32'h22, 32'h11};
    run("t2", 3'd4, 1'b1, 1'b0);
    chk_val("t2_w_before_aw", 32'(w_first < aw_first), 1);
    chk_val("t2_aw_stable", aw_unstable, 0);
    chk_val("t2_n_aw", n_aw, 4);
    chk_val("t2_n_r", n_r, 4);
    chk_val("t2_err", 32'(err), 0);
    chk_val("t2_done_pulses", done_cnt, 1);

    // SLVERR on the write of register 2
    between();
    aw_delay = 0; bad_b = 2;
    cfg_words = {32'd4, 32'd3, 32'd2, 32'd1};
    run("t3", 3'd4, 1'b1, 1'b0);
    chk_val("t3_err", 32'(err), 1);
    chk_val("t3_err_code", 32'(err_code), 1);
    chk_val("t3_err_idx", 32'(err_idx), 2);
    chk_val("t3_n_aw", n_aw, 3);
    chk_val("t3_n_ar", n_ar, 0);
    chk_val("t3_done_pulses", done_cnt, 1);

    // readback mismatch on register 1
    between();
    bad_b = -1; bad_r = 1;
    run("t4", 3'd4, 1'b1, 1'b0);
    chk_val("t4_err", 32'(err), 1);
    chk_val("t4_err_code", 32'(err_code), 2);
    chk_val("t4_err_idx", 32'(err_idx), 1);
    chk_val("t4_n_r", n_r, 2);
    chk_val("t4_done_pulses", done_cnt, 1);

    // arready never comes: 16-cycle timeout in RD_ADDR
    between();
    bad_r = -1; ar_never = 1'b1;
    run("t5", 3'd4, 1'b1, 1'b0);
    chk_val("t5_err", 32'(err), 1);
    chk_val("t5_err_code", 32'(err_code), 3);
    chk_val("t5_err_idx", 32'(err_idx), 0);
    chk_val("t5_ar_cycles", ar_high, 16);
    chk_val("t5_arvalid_end", 32'(m_axi_arvalid), 0);
    chk_val("t5_n_aw", n_aw, 4);
    chk_val("t5_done_pulses", done_cnt, 1);

    // reset while waiting for B, then restart with num_regs=0 (clamped to 4)
    between();
    ar_never = 1'b0;
    @(negedge clk);
    num_regs = 3'd4; verify_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (m_axi_bready) break;
      @(negedge clk);
    end
    chk_val("t6_reached_wr_resp", 32'(m_axi_bready), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_val("t6_rst_busy", 32'(busy), 0);
    chk_val("t6_rst_bready", 32'(m_axi_bready), 0);
    chk_val("t6_rst_err", 32'(err), 0);
    chk_val("t6_no_done", done_cnt, 0);
    clr_stats();
    rst = 1'b0;
    cfg_words = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    run("t6", 3'd0, 1'b1, 1'b0);
    chk_val("t6_n_aw", n_aw, 4);
    chk_val("t6_awaddr3", 32'(aw_q[3]), 32'hC);
    chk_val("t6_wdata0", w_q[0], 32'hA0);
    chk_val("t6_wdata3", w_q[3], 32'hA3);
    chk_val("t6_n_r", n_r, 4);
    chk_val("t6_err", 32'(err), 0);
    chk_val("t6_done_pulses", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
